// File: rtl/fetch_decode_if.sv
// Signal bundle between the LEGv8 pipeline front end and the rest of the core:
// instruction-memory port, ID-stage control decisions, EX/MEM hazard info, IF/ID outputs.
interface fetch_decode_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               br_taken;
  logic               uncond_br;
  logic               ex_mem_read;
  logic               ex_reg_write;
  logic [4:0]         ex_rd;
  logic               mem_mem_read;
  logic [4:0]         mem_rd;
  logic [10:0]        opcode;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;
  logic               stall;

  // Front end side.
  modport slave (
    output imem_addr, opcode, if_id_instr, if_id_pc, if_id_valid, stall,
    input  imem_instr, br_taken, uncond_br, ex_mem_read, ex_reg_write, ex_rd,
           mem_mem_read, mem_rd
  );

  // Core / environment side.
  modport master (
    input  imem_addr, opcode, if_id_instr, if_id_pc, if_id_valid, stall,
    output imem_instr, br_taken, uncond_br, ex_mem_read, ex_reg_write, ex_rd,
           mem_mem_read, mem_rd
  );
endinterface

// File: rtl/fetch_decode_front.sv
// LEGv8 pipeline front end: PC, IF/ID register, branch target generation and
// ID-stage hazard detection (load-use and CBZ operand readiness).
module fetch_decode_front #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  fetch_decode_if.slave  bus
);

  // Handshake: if_id_valid qualifies the IF/ID contents (0 = bubble). There is
  // no ready; stall is the only backpressure and, while high, PC and IF/ID hold.

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;

  logic [10:0] opcode;
  logic [4:0]  rn, rm, rt;
  logic        uses_rn, uses_rm, uses_rt, is_cbz;
  logic        load_use_haz, cbz_haz, stall;

  logic [ADDR_W-1:0] off26, off19, br_target;

  assign opcode = if_id_instr_q[31:21];
  assign rn     = if_id_instr_q[9:5];
  assign rm     = if_id_instr_q[20:16];
  assign rt     = if_id_instr_q[4:0];

  // Source-register usage per opcode; anything unrecognised reads nothing.
  always_comb begin
    uses_rn = 1'b0;
    uses_rm = 1'b0;
    uses_rt = 1'b0;
    is_cbz  = 1'b0;
    casez (opcode)
      11'b10101011000,                 // ADDS
      11'b11101011000,                 // SUBS
      11'b10001010000,                 // AND
      11'b11001010000: begin           // EOR
        uses_rn = 1'b1;
        uses_rm = 1'b1;
      end
      11'b1001000100?,                 // ADDI
      11'b11111000010,                 // LDUR
      11'b11010011010: begin           // LSR
        uses_rn = 1'b1;
      end
      11'b11111000000: begin           // STUR
        uses_rn = 1'b1;
        uses_rt = 1'b1;
      end
      11'b10110100???: begin           // CBZ
        uses_rt = 1'b1;
        is_cbz  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ex_rd != 31 in the compare implies the matching source is not X31 either.
  assign load_use_haz = bus.ex_mem_read && (bus.ex_rd != 5'd31) &&
                        ((uses_rn && (rn == bus.ex_rd)) ||
                         (uses_rm && (rm == bus.ex_rd)) ||
                         (uses_rt && (rt == bus.ex_rd)));

  // CBZ tests its operand in ID, so it also waits for an ALU result in EX and a load in MEM.
  assign cbz_haz = is_cbz && (rt != 5'd31) &&
                   ((bus.ex_reg_write && (bus.ex_rd == rt)) ||
                    (bus.mem_mem_read && (bus.mem_rd == rt)));

  assign stall = if_id_valid_q && (load_use_haz || cbz_haz);

  assign off26 = {{(ADDR_W-28){if_id_instr_q[25]}}, if_id_instr_q[25:0], 2'b00};
  assign off19 = {{(ADDR_W-21){if_id_instr_q[23]}}, if_id_instr_q[23:5], 2'b00};
  assign br_target = if_id_pc_q + (bus.uncond_br ? off26 : off19);

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if (stall) begin
      // Hold everything; a pending br_taken is re-evaluated once the stall clears.
    end else if (bus.br_taken && if_id_valid_q) begin
      pc_d          = br_target;
      if_id_instr_d = '0;
      if_id_pc_d    = '0;
      if_id_valid_d = 1'b0;
    end else begin
      pc_d          = pc_q + ADDR_W'(4);
      if_id_instr_d = bus.imem_instr;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= '0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.opcode      = opcode;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.stall       = stall;

endmodule
